// File: rtl/matmul_result_drain.sv
// Result buffer behind the matmul kernel's v2 write port. Counts writes after each
// tstart and, once a run is complete, streams the buffer out in address order.
module matmul_result_drain #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_RESULTS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tstart,
    input  logic [ADDR_W-1:0] v2_addr,
    input  logic              v2_wr_en,
    input  logic [DATA_W-1:0] v2_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int                DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_RESULTS - 1);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(NUM_RESULTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_FINISH} state_t;

    state_t            state_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic              rd_issue_done_reg;
    logic              rd_valid_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rd_last_reg;
    logic              skid_valid_reg;
    logic [ADDR_W-1:0] skid_addr_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              skid_last_reg;
    logic              out_valid_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_last_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_data;

    logic       wr_fire;
    logic       pop;
    logic [1:0] occupancy;
    logic [1:0] occupancy_after_pop;
    logic       rd_issue;

    // Reads in flight plus buffered beats never exceed two, so one skid entry suffices.
    assign wr_fire             = !rst && (state_reg == S_CAPTURE) && v2_wr_en;
    assign pop                 = out_valid_reg && out_ready;
    assign occupancy           = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(rd_valid_reg);
    assign occupancy_after_pop = occupancy - 2'(pop);
    assign rd_issue            = (state_reg == S_DRAIN) && !rd_issue_done_reg
                                 && (occupancy_after_pop < 2'd2);

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[v2_addr] <= v2_wr_data;
        if (rd_issue)
            mem_rd_data <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            count_reg         <= '0;
            rd_ptr_reg        <= '0;
            rd_issue_done_reg <= 1'b0;
            rd_valid_reg      <= 1'b0;
            rd_addr_reg       <= '0;
            rd_last_reg       <= 1'b0;
            skid_valid_reg    <= 1'b0;
            skid_addr_reg     <= '0;
            skid_data_reg     <= '0;
            skid_last_reg     <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_addr_reg      <= '0;
            out_data_reg      <= '0;
            out_last_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (tstart) begin
                        state_reg <= S_CAPTURE;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        err_reg   <= v2_wr_en;
                    end else if (v2_wr_en) begin
                        err_reg <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (tstart)
                        err_reg <= 1'b1;
                    if (v2_wr_en) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_COUNT) begin
                            state_reg         <= S_DRAIN;
                            rd_ptr_reg        <= '0;
                            rd_issue_done_reg <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tstart || v2_wr_en)
                        err_reg <= 1'b1;
                    if (rd_issue) begin
                        if (rd_ptr_reg == LAST_ADDR)
                            rd_issue_done_reg <= 1'b1;
                        else
                            rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    rd_valid_reg <= rd_issue;
                    rd_addr_reg  <= rd_ptr_reg;
                    rd_last_reg  <= (rd_ptr_reg == LAST_ADDR);
                    // Output register refills from skid first so beat order is kept.
                    if (!out_valid_reg || pop) begin
                        if (skid_valid_reg) begin
                            out_valid_reg  <= 1'b1;
                            out_addr_reg   <= skid_addr_reg;
                            out_data_reg   <= skid_data_reg;
                            out_last_reg   <= skid_last_reg;
                            skid_valid_reg <= rd_valid_reg;
                            skid_addr_reg  <= rd_addr_reg;
                            skid_data_reg  <= mem_rd_data;
                            skid_last_reg  <= rd_last_reg;
                        end else if (rd_valid_reg) begin
                            out_valid_reg <= 1'b1;
                            out_addr_reg  <= rd_addr_reg;
                            out_data_reg  <= mem_rd_data;
                            out_last_reg  <= rd_last_reg;
                        end else begin
                            out_valid_reg <= 1'b0;
                        end
                    end else if (rd_valid_reg) begin
                        skid_valid_reg <= 1'b1;
                        skid_addr_reg  <= rd_addr_reg;
                        skid_data_reg  <= mem_rd_data;
                        skid_last_reg  <= rd_last_reg;
                    end
                    if (pop && out_last_reg) begin
                        state_reg     <= S_FINISH;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Scoreboard bench for matmul_result_drain: a 256-result instance and a 4-result instance,
// each checked against a queue of expected beats built from a simple memory model.
module tb_matmul_result_drain;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int N  = 256;
    localparam int N4 = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          tstart = 1'b0, we = 1'b0, ready = 1'b1;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic          ov, ol, busy, done, err;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;

    logic          tstart4 = 1'b0, we4 = 1'b0, ready4 = 1'b1;
    logic [AW-1:0] wa4 = '0;
    logic [DW-1:0] wd4 = '0;
    logic          ov4, ol4, busy4, done4, err4;
    logic [AW-1:0] oa4;
    logic [DW-1:0] od4;

    matmul_result_drain #(.ADDR_W(AW), .DATA_W(DW), .NUM_RESULTS(N)) dut (
        .clk(clk), .rst(rst), .tstart(tstart), .v2_addr(wa), .v2_wr_en(we),
        .v2_wr_data(wd), .out_valid(ov), .out_ready(ready), .out_addr(oa),
        .out_data(od), .out_last(ol), .busy(busy), .done(done), .err(err));

    matmul_result_drain #(.ADDR_W(AW), .DATA_W(DW), .NUM_RESULTS(N4)) dut4 (
        .clk(clk), .rst(rst), .tstart(tstart4), .v2_addr(wa4), .v2_wr_en(we4),
        .v2_wr_data(wd4), .out_valid(ov4), .out_ready(ready4), .out_addr(oa4),
        .out_data(od4), .out_last(ol4), .busy(busy4), .done(done4), .err(err4));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: plain memory image plus write counter per instance.
    logic [DW-1:0] model_mem  [N];
    logic [DW-1:0] model4_mem [N];
    int  model_cnt = 0, model4_cnt = 0;
    bit  model_cap = 0, model4_cap = 0;
    beat_t exp_q[$];
    beat_t exp4_q[$];

    // Ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    int ready_mode = 0;
    int rcyc = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            default: ready = 1'($urandom_range(0, 1));
        endcase
        ready4 = 1'($urandom_range(0, 1));
        rcyc++;
    end

    // Monitor for the 256-result instance.
    int    beats = 0, done_cnt = 0;
    bit    last_xfer = 0, stall_prev = 0;
    beat_t held;
    always @(negedge clk) begin
        if (rst) begin
            last_xfer  = 0;
            stall_prev = 0;
        end else begin
            if (last_xfer) begin
                check("done_after_last", done, 1);
                check("busy_fall", busy, 0);
                check("valid_drop", ov, 0);
                done_cnt++;
                last_xfer = 0;
            end else if (done) begin
                check("spurious_done", done, 0);
            end
            if (stall_prev) begin
                check("stall_valid", ov, 1);
                check("stall_addr", oa, held.a);
                check("stall_data", od, held.d);
                check("stall_last", ol, held.l);
            end
            stall_prev = ov && !ready;
            if (stall_prev) held = '{a: oa, d: od, l: ol};
            if (ov && ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_addr", oa, e.a);
                    check("beat_data", od, e.d);
                    check("beat_last", ol, e.l);
                    $display("beat addr=%0d data=0x%0h last=%0b", oa, od, ol);
                end
                beats++;
                if (ol) last_xfer = 1;
            end
        end
    end

    // Monitor for the 4-result instance.
    int done4_cnt = 0;
    bit last4_xfer = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (last4_xfer) begin
                check("done4_after_last", done4, 1);
                check("busy4_fall", busy4, 0);
                done4_cnt++;
                last4_xfer = 0;
            end
            if (ov4 && ready4) begin
                check("beat4_expected", exp4_q.size() != 0, 1);
                if (exp4_q.size() != 0) begin
                    beat_t e;
                    e = exp4_q.pop_front();
                    check("beat4_addr", oa4, e.a);
                    check("beat4_data", od4, e.d);
                    check("beat4_last", ol4, e.l);
                    $display("beat4 addr=%0d data=0x%0h last=%0b", oa4, od4, ol4);
                end
                if (ol4) last4_xfer = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tstart = 1'b1;
        model_cap = 1;
        model_cnt = 0;
        tick();
        tstart = 1'b0;
    endtask

    task automatic kwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; wa = a; wd = d;
        if (model_cap) begin
            model_mem[a] = d;
            model_cnt++;
            if (model_cnt == N) begin
                model_cap = 0;
                for (int i = 0; i < N; i++)
                    exp_q.push_back('{a: AW'(i), d: model_mem[i], l: (i == N - 1)});
            end
        end
        tick();
        we = 1'b0;
    endtask

    task automatic start_and_write(input bit reversed, input bit gapped, input int salt);
        int cyc = 0;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            while (gapped && (cyc % 3) == 2) begin
                tick();
                cyc++;
            end
            if (reversed)
                kwrite(AW'(N - 1 - i), $urandom);
            else
                kwrite(AW'(i), DW'(3 * i + salt));
            cyc++;
        end
    endtask

    task automatic finish_drain();
        int k = 0;
        int d0 = done_cnt;
        while (!ov && k < 2) begin
            tick();
            k++;
        end
        check("first_valid_latency", ov, 1);
        k = 0;
        while (done_cnt == d0 && k < 8 * N) begin
            tick();
            k++;
        end
        check("drain_completed", done_cnt != d0, 1);
        check("queue_empty", exp_q.size(), 0);
        check("err_clean", err, 0);
    endtask

    task automatic w4(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we4 = 1'b1; wa4 = a; wd4 = d;
        if (model4_cap) begin
            model4_mem[a] = d;
            model4_cnt++;
            if (model4_cnt == N4) begin
                model4_cap = 0;
                for (int i = 0; i < N4; i++)
                    exp4_q.push_back('{a: AW'(i), d: model4_mem[i], l: (i == N4 - 1)});
            end
        end
        tick();
        we4 = 1'b0;
    endtask

    task automatic start4();
        tstart4 = 1'b1;
        model4_cap = 1;
        model4_cnt = 0;
        tick();
        tstart4 = 1'b0;
    endtask

    task automatic wait_done4();
        int k = 0;
        int d0 = done4_cnt;
        while (done4_cnt == d0 && k < 200) begin
            tick();
            k++;
        end
        check("drain4_completed", done4_cnt != d0, 1);
        check("queue4_empty", exp4_q.size(), 0);
    endtask

    initial begin
        // Reset with random activity on every input.
        ready_mode = 2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tstart = 1'($urandom); we = 1'($urandom); wa = AW'($urandom); wd = $urandom;
            tstart4 = 1'($urandom); we4 = 1'($urandom);
            tick();
            check("rst_valid", ov, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_addr", oa, 0);
            check("rst_data", od, 0);
            check("rst4_valid", ov4, 0);
            check("rst4_err", err4, 0);
        end
        tstart = 0; we = 0; tstart4 = 0; we4 = 0;
        rst = 1'b0;
        tick();

        // Small instance: fill every address, then duplicates plus a write during drain.
        start4();
        for (int i = 0; i < N4; i++) w4(AW'(i), DW'(100 + i));
        wait_done4();
        check("err4_clean", err4, 0);
        start4();
        w4(0, 10); w4(1, 11); w4(1, 12); w4(2, 13);
        w4(3, 99);
        check("err4_write_in_drain", err4, 1);
        wait_done4();
        check("err4_sticky", err4, 1);
        tick();
        start4();
        check("err4_cleared_by_tstart", err4, 0);

        // Full contiguous run, then backpressure, then reversed gapped writes.
        ready_mode = 0;
        start_and_write(0, 0, 0);
        finish_drain();
        ready_mode = 1;
        start_and_write(0, 0, 7);
        finish_drain();
        ready_mode = 2;
        start_and_write(1, 1, 0);
        finish_drain();

        // Reset in the middle of a drain, then a clean run.
        ready_mode = 0;
        start_and_write(0, 0, 11);
        begin
            int k = 0;
            int b0 = beats;
            while (beats < b0 + 10 && k < 50) begin
                tick();
                k++;
            end
            check("mid_drain_reached", beats >= b0 + 10, 1);
        end
        rst = 1'b1;
        tick();
        check("mid_rst_valid", ov, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", oa, 0);
        check("mid_rst_data", od, 0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        start_and_write(0, 0, 5);
        finish_drain();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
Result-capture stage directly downstream of the HIR-generated matmul kernel. It acts as the memory behind the kernel's v2 write port, counts result writes after each tstart, and once the expected number of results has been written, streams the buffer out in ascending address order over a valid/ready interface to the host or testbench side.

Parameters:
ADDR_W, 8, width of kernel write address and of out_addr.
DATA_W, 32, result word width.
NUM_RESULTS, 256, writes expected per kernel run; legal range 1..2**ADDR_W.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
tstart  in  1  kernel start pulse, shared with the matmul tstart.
v2_addr  in  ADDR_W  kernel write address.
v2_wr_en  in  1  kernel write strobe.
v2_wr_data  in  DATA_W  kernel write data.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_addr  out  ADDR_W  buffer address of the current beat.
out_data  out  DATA_W  buffer word at out_addr.
out_last  out  1  high on beat with out_addr == NUM_RESULTS-1.
busy  out  1  high in CAPTURE or DRAIN.
done  out  1  one-cycle pulse after the last beat is accepted.
err  out  1  sticky protocol-error flag.

Behaviour:
- Storage: 2**ADDR_W x DATA_W array with synchronous read and 1-cycle read latency. Reset does not clear it.
- Reset values: state IDLE; out_valid, out_last, busy, done and err are 0; out_addr and out_data are 0; write count is 0.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - tstart=1: go to CAPTURE, clear write count, clear err.
  - v2_wr_en=1: ignored (no memory write) and err is set.
- CAPTURE:
  - v2_wr_en=1: write mem[v2_addr] <= v2_wr_data and increment the count.
  - Duplicate addresses: last write wins, and every write still counts.
  - The write that brings the count to NUM_RESULTS moves the block to DRAIN on the next cycle, with read pointer 0.
  - tstart: ignored and err is set.
- DRAIN:
  - Prefetch read pipeline. The first out_valid is asserted no later than 2 cycles after entering DRAIN.
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_addr, out_data and out_last are held stable.
  - With out_ready held at 1, one beat is issued per cycle with no bubbles; a skid register is used as needed.
  - Beats run over addresses 0..NUM_RESULTS-1 in order, with no drops or duplicates.
  - After the last beat is accepted, out_valid drops on the next cycle and the block goes to DONE.
  - v2_wr_en or tstart during DRAIN: ignored and err is set. Memory is not modified.
- DONE: done=1 for exactly one cycle, then IDLE. A tstart in DONE is ignored (no error).
- err stays set until rst, or until a tstart accepted in IDLE.
- busy = (state == CAPTURE || state == DRAIN).
- Count register is ADDR_W+1 bits wide so that NUM_RESULTS = 2**ADDR_W is reachable without wrap.
- Read pointer stops at NUM_RESULTS-1 and never wraps.
- Reset mid-operation: the cycle after rst, state is IDLE and all outputs are at reset values. Any partial drain is abandoned; memory contents are retained.
- Simultaneous events:
  - tstart with v2_wr_en in IDLE: tstart is honored, but the write is dropped and flagged (err=1 after the transition).
  - rst dominates all other inputs.

Test Plan:
- Reset: hold rst for 3 cycles with random inputs -> out_valid, busy, done and err are 0, and out_addr/out_data are 0.
- Full run: tstart pulse, then 256 contiguous writes with v2_addr=i and data=3*i; out_ready=1 -> out_valid within 2 cycles of the last write, then 256 consecutive beats with out_data=3*i and out_addr=i. out_last only at out_addr=255. done pulses once on the cycle after beat 255; busy falls with it.
- Backpressure: same run with out_ready pattern 1,0,0,1 repeating -> exactly 256 accepted beats in order, with data and address stable across every stall cycle.
- Out-of-order, gapped writes: v2_addr=255-i, with v2_wr_en low every third cycle -> drain still ascending, out_data[a] matches the value written to a; DRAIN is entered only after the 256th write.
- Duplicate writes and error: NUM_RESULTS=4, writes to addresses 0,1,1,2 with data 10,11,12,13 -> DRAIN after 4 writes, beats {0:10, 1:12, 2:13, 3:stale}. A v2_wr_en during DRAIN sets err=1 and leaves beat data unchanged; the next tstart in IDLE clears err.
- Reset mid-drain: assert rst after 10 accepted beats -> out_valid=0 the following cycle and state is IDLE. A new tstart plus 256 writes completes a correct full drain.
